generic_fifo_sc_b: RTL and testbench

//  Next-gen single-clock FIFO: parametrised width/depth, exact occupancy count,

---
 rtl/fifo_sc_pkg.sv | 24 ++
 rtl/fifo_sc_ram.sv | 31 +++
 rtl/generic_fifo_sc_b.sv | 127 ++++++++++++
 tb/tb_generic_fifo_sc_b.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sc_pkg.sv
// Shared constants and types for the single-clock FIFO.
// Default geometry, status-bus flag indices, queue-operation encoding.
package fifo_sc_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 4;

  localparam int FL_EMPTY  = 0;
  localparam int FL_AEMPTY = 1;
  localparam int FL_AFULL  = 2;
  localparam int FL_FULL   = 3;
  localparam int FL_OVF    = 4;
  localparam int FL_UNF    = 5;
  localparam int NFL       = 6;

  // {accepted write, accepted pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port storage, one write and one registered read port.
// Ports: clk, clr (sync, clears read reg), we/waddr/wdata, re/raddr/rdata.
module fifo_sc_ram
  import fifo_sc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read register holds its value between reads
  always_ff @(posedge clk) begin
    if (clr) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/generic_fifo_sc_b.sv
// Single-clock FIFO with exact count, programmable thresholds, sticky errors.
// Ports: clk, rst (sync, active-low), clr, din, wr_en, rd_en, afull_th,
//   aempty_th, dout, dout_vld, full, empty, afull, aempty, cnt, ovf, unf.
// Build option: SC_FIFO_FWFT_EN selects first-word-fall-through output.
module generic_fifo_sc_b
  import fifo_sc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW:0]   afull_th,
  input  logic [AW:0]   aempty_th,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [AW:0]   cnt,
  output logic          ovf,
  output logic          unf
);

  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0]  wp_q;
  logic [AW-1:0]  rp_q;
  logic [AW:0]    cnt_q;
  logic [AW:0]    cnt_nxt;
  logic [NFL-1:0] fl_q;
  logic [NFL-1:0] fl_nxt;
  logic           vld_q;
  logic           vld_nxt;
  logic           sync_clr;
  logic           wr_ok;
  logic           rd_ok;
  logic           ld;
  logic           unf_ev;
  op_e            op;

  assign sync_clr = !rst || clr;
  assign wr_ok    = wr_en && !fl_q[FL_FULL];

`ifdef SC_FIFO_FWFT_EN
  // cnt includes the output stage; words still in RAM = cnt - vld
  logic [AW:0] mcnt;

  assign mcnt    = cnt_q - {{AW{1'b0}}, vld_q};
  assign rd_ok   = rd_en && vld_q;
  assign ld      = (mcnt != '0) && (!vld_q || rd_ok);
  assign vld_nxt = ld || (vld_q && !rd_ok);
  assign unf_ev  = rd_en && !vld_q;
`else
  assign rd_ok   = rd_en && !fl_q[FL_EMPTY];
  assign ld      = rd_ok;
  assign vld_nxt = rd_ok;
  assign unf_ev  = rd_en && fl_q[FL_EMPTY];
`endif

  assign op = op_e'({wr_ok, rd_ok});

  always_comb begin
    cnt_nxt = cnt_q;
    unique case (op)
      OP_PUSH: cnt_nxt = cnt_q + CNT_ONE;
      OP_POP:  cnt_nxt = cnt_q - CNT_ONE;
      default: cnt_nxt = cnt_q;
    endcase
    if (sync_clr) cnt_nxt = '0;

    // flags follow the post-edge count and current thresholds
    fl_nxt            = '0;
    fl_nxt[FL_EMPTY]  = cnt_nxt == '0;
    fl_nxt[FL_FULL]   = cnt_nxt == CNT_FULL;
    fl_nxt[FL_AFULL]  = cnt_nxt >= afull_th;
    fl_nxt[FL_AEMPTY] = cnt_nxt <= aempty_th;
    fl_nxt[FL_OVF]    = !sync_clr &&
                        (fl_q[FL_OVF] || (wr_en && fl_q[FL_FULL]));
    fl_nxt[FL_UNF]    = !sync_clr && (fl_q[FL_UNF] || unf_ev);
  end

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      wp_q  <= '0;
      rp_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      if (wr_ok) wp_q <= wp_q + PTR_ONE;
      if (ld)    rp_q <= rp_q + PTR_ONE;
      vld_q <= vld_nxt;
    end
    cnt_q <= cnt_nxt;
    fl_q  <= fl_nxt;
  end

  fifo_sc_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .clr  (sync_clr),
    .we   (wr_ok && !sync_clr),
    .waddr(wp_q),
    .wdata(din),
    .re   (ld && !sync_clr),
    .raddr(rp_q),
    .rdata(dout)
  );

  assign dout_vld = vld_q;
  assign cnt      = cnt_q;
  assign full     = fl_q[FL_FULL];
  assign empty    = fl_q[FL_EMPTY];
  assign afull    = fl_q[FL_AFULL];
  assign aempty   = fl_q[FL_AEMPTY];
  assign ovf      = fl_q[FL_OVF];
  assign unf      = fl_q[FL_UNF];

endmodule

// File: tb/tb_generic_fifo_sc_b.sv
// Self-checking bench for generic_fifo_sc_b (DW=8, AW=4).
// Table vectors, directed corner sequences, random traffic vs queue model.
module tb_generic_fifo_sc_b;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;
  logic [4:0] afull_th;
  logic [4:0] aempty_th;
  logic [7:0] dout;
  logic       dout_vld;
  logic       full;
  logic       empty;
  logic       afull;
  logic       aempty;
  logic [4:0] cnt;
  logic       ovf;
  logic       unf;

  int checks = 0;
  int errors = 0;

  generic_fifo_sc_b #(.DW(8), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .din      (din),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .afull_th (afull_th),
    .aempty_th(aempty_th),
    .dout     (dout),
    .dout_vld (dout_vld),
    .full     (full),
    .empty    (empty),
    .afull    (afull),
    .aempty   (aempty),
    .cnt      (cnt),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // reference model: queue of stored words plus output view
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_vld;
  bit         m_ovf;
  bit         m_unf;

  function automatic int m_cnt();
`ifdef SC_FIFO_FWFT_EN
    return mq.size() + int'(m_vld);
`else
    return mq.size();
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit w, input bit r, input bit c,
                            input logic [7:0] d);
    int  n;
    bit  full_p;
    bit  empty_p;
    bit  pop;
    n       = m_cnt();
    full_p  = (n == 16);
    empty_p = (n == 0);
    if (!rst || c) begin
      mq.delete();
      m_ovf  = 0;
      m_unf  = 0;
      m_vld  = 0;
      m_dout = 8'h00;
      return;
    end
    if (w && full_p) m_ovf = 1;
`ifdef SC_FIFO_FWFT_EN
    pop = r && m_vld;
    if (r && !m_vld) m_unf = 1;
    if ((!m_vld || pop) && mq.size() > 0) begin
      m_dout = mq.pop_front();
      m_vld  = 1;
    end else if (pop) begin
      m_vld = 0;
    end
`else
    pop = r && !empty_p;
    if (r && empty_p) m_unf = 1;
    m_vld = 0;
    if (pop) begin
      m_dout = mq.pop_front();
      m_vld  = 1;
    end
`endif
    if (w && !full_p) mq.push_back(d);
  endtask

  task automatic compare_model();
    int n;
    n = m_cnt();
    check("cnt", int'(cnt), n);
    check("full", int'(full), int'(n == 16));
    check("empty", int'(empty), int'(n == 0));
    check("afull", int'(afull), int'(n >= int'(afull_th)));
    check("aempty", int'(aempty), int'(n <= int'(aempty_th)));
    check("ovf", int'(ovf), int'(m_ovf));
    check("unf", int'(unf), int'(m_unf));
    check("dout_vld", int'(dout_vld), int'(m_vld));
    check("dout", int'(dout), int'(m_dout));
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] d,
                      input bit c);
    wr_en = w;
    rd_en = r;
    din   = d;
    clr   = c;
    @(posedge clk);
    model_edge(w, r, c, d);
    #1;
    compare_model();
    wr_en = 0;
    rd_en = 0;
    clr   = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    rst = 1;
  endtask

  // pop one word, returning the word this pop consumed
  task automatic pop_word(output bit got, output logic [7:0] w);
    got = 0;
    w   = 8'h00;
`ifdef SC_FIFO_FWFT_EN
    if (dout_vld) begin
      got = 1;
      w   = dout;
    end
    step(0, 1, 8'h00, 0);
`else
    step(0, 1, 8'h00, 0);
    if (dout_vld) begin
      got = 1;
      w   = dout;
    end
`endif
  endtask

  typedef struct {
    bit         w;
    bit         r;
    bit         c;
    logic [7:0] d;
    int         cnt;
    bit         e;
    bit         f;
    bit         o;
    bit         u;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit         got;
    logic [7:0] w;
    int         npop;
    int         pct_w;
    int         pct_r;

    tbl[0] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 8'h11, 1, 0, 0, 0, 1};
    tbl[2] = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 1};
    tbl[3] = '{0, 1, 0, 8'h00, 0, 1, 0, 0, 1};
    tbl[4] = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 0};
    tbl[5] = '{1, 0, 0, 8'h22, 1, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 8'h33, 2, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 1, 8'h44, 0, 1, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 0};

    rst       = 1;
    clr       = 0;
    wr_en     = 0;
    rd_en     = 0;
    din       = 8'h00;
    afull_th  = 5'd14;
    aempty_th = 5'd2;

    do_reset();
    check("rst_empty", int'(empty), 1);
    check("rst_aempty", int'(aempty), 1);
    check("rst_full", int'(full), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_ovf_unf", int'({ovf, unf}), 0);

    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].c);
      check($sformatf("tbl%0d_cnt", i), int'(cnt), tbl[i].cnt);
      check($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].e));
      check($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].f));
      check($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].o));
      check($sformatf("tbl%0d_unf", i), int'(unf), int'(tbl[i].u));
    end

    // fill 0x00..0x0F then one extra write
    for (int i = 0; i < 17; i++) begin
      step(1, 0, 8'(i), 0);
      if (i == 12) check("fill_afull13", int'(afull), 0);
      if (i == 13) check("fill_afull14", int'(afull), 1);
      if (i == 14) check("fill_full15", int'(full), 0);
      if (i == 15) begin
        check("fill_full16", int'(full), 1);
        check("fill_cnt16", int'(cnt), 16);
        check("fill_ovf16", int'(ovf), 0);
      end
    end
    check("fill_ovf17", int'(ovf), 1);
    check("fill_cnt17", int'(cnt), 16);

    // drain in order, then one extra read
    npop = 0;
    for (int i = 0; i < 16; i++) begin
      pop_word(got, w);
      check("drain_vld", int'(got), 1);
      check("drain_data", int'(w), i);
      if (got) npop++;
    end
    check("drain_npop", npop, 16);
    check("drain_cnt", int'(cnt), 0);
    check("drain_unf0", int'(unf), 0);
    step(0, 1, 8'h00, 0);
    check("drain_unf1", int'(unf), 1);
    check("drain_cnt_x", int'(cnt), 0);

    // concurrent traffic at cnt=8, pointers wrap several times
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h40 + i), 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 8'(8'h80 + i), 0);
      if (i > 0) check("conc_cnt", int'(cnt), 8);
    end

    // clear mid-stream at cnt=9 with sticky flags set
    step(1, 0, 8'hC0, 0);
    check("pre_clr_cnt", int'(cnt), 9);
    step(0, 0, 8'h00, 1);
    check("clr_cnt", int'(cnt), 0);
    check("clr_empty", int'(empty), 1);
    check("clr_ovf", int'(ovf), 0);
    check("clr_unf", int'(unf), 0);

    // full + wr&rd: only the read is taken
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'hD0 + i), 0);
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'hEE, 0);
    check("fullrw_cnt", int'(cnt), 15);
    check("fullrw_ovf", int'(ovf), 1);

    // threshold change takes effect at the next edge
    afull_th = 5'd16;
    step(0, 0, 8'h00, 0);
    check("th_afull16", int'(afull), 0);
    afull_th  = 5'd15;
    aempty_th = 5'd15;
    step(0, 0, 8'h00, 0);
    check("th_afull15", int'(afull), 1);
    check("th_aempty15", int'(aempty), 1);
    afull_th  = 5'd14;
    aempty_th = 5'd2;

    // afull_th==0 makes afull assert out of reset
    afull_th = 5'd0;
    do_reset();
    check("rst_afull_th0", int'(afull), 1);
    afull_th = 5'd14;
    step(0, 0, 8'h00, 0);

`ifdef SC_FIFO_FWFT_EN
    step(1, 0, 8'hA5, 0);
    check("fwft_vld_e1", int'(dout_vld), 0);
    step(0, 0, 8'h00, 0);
    check("fwft_vld_e2", int'(dout_vld), 1);
    check("fwft_dout", int'(dout), 8'hA5);
    step(0, 0, 8'h00, 1);
`endif

    // random traffic with shifting bias, rare clr, threshold moves
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        pct_w = $urandom_range(20, 80);
        pct_r = $urandom_range(20, 80);
      end
      if ($urandom_range(0, 99) == 0) begin
        afull_th  = 5'($urandom_range(0, 16));
        aempty_th = 5'($urandom_range(0, 16));
      end
      step(int'($urandom_range(0, 99)) < pct_w,
           int'($urandom_range(0, 99)) < pct_r,
           8'($urandom),
           $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
